// File: rtl/put_channel_arbiter.sv
// Packet-granular round-robin arbiter sharing one put channel between NUM_REQ
// producers. A single registered output stage feeds the put channel, and every
// beat the channel accepts is mirrored one cycle later onto an analysis tap.
//
// state | meaning
// IDLE  | no packet in flight; a new grant may be issued when cfg_enable is high
// LOCK  | multi-beat packet in flight; only the owner may send until its last beat
module put_channel_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic                      cfg_enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [SRC_W-1:0]          out_src,
    output logic                      ap_valid,
    output logic [DATA_W-1:0]         ap_data,
    output logic                      ap_last,
    output logic [SRC_W-1:0]          ap_src,
    output logic [CNT_W-1:0]          pkt_count,
    output logic                      idle
);

    typedef enum logic [0:0] {IDLE, LOCK} state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    owner_q, owner_d;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic [SRC_W-1:0]    out_src_q;
    logic                ap_valid_q;
    logic [DATA_W-1:0]   ap_data_q;
    logic                ap_last_q;
    logic [SRC_W-1:0]    ap_src_q;
    logic [CNT_W-1:0]    pkt_count_q;

    logic                slot_free;
    logic                grant_found;
    logic [SRC_W-1:0]    grant_idx;
    logic [SRC_W-1:0]    sel;
    logic                grant_en;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic                accept;
    logic [DATA_W-1:0]   beat_data;
    logic                beat_last;
    logic [SRC_W-1:0]    sel_next;
    int                  scan_idx;
    logic                out_fire;

    // Grant selection, handshake and next-state logic.
    // req_ready is gated by reset so nothing is accepted while reset is held.
    always_comb begin
        slot_free   = !out_valid_q | out_ready;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(scan_idx);
            end
        end

        sel      = (state_q == LOCK) ? owner_q : grant_idx;
        grant_en = nvdla_core_rstn & ((state_q == LOCK) | (cfg_enable & grant_found));

        req_ready_c = '0;
        beat_data   = '0;
        beat_last   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == sel) begin
                req_ready_c[i] = grant_en & slot_free;
                beat_data      = req_data[i*DATA_W +: DATA_W];
                beat_last      = req_last[i];
            end
        end
        accept   = |(req_valid & req_ready_c);
        sel_next = (sel == SRC_W'(NUM_REQ - 1)) ? '0 : sel + SRC_W'(1);

        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (accept) begin
            if (beat_last) begin
                state_d  = IDLE;
                rr_ptr_d = sel_next;
            end else begin
                state_d = LOCK;
                owner_d = sel;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Output stage: load on accept (also while draining), otherwise empty on drain.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= beat_data;
            out_last_q  <= beat_last;
            out_src_q   <= sel;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_fire = out_valid_q & out_ready;

    // Analysis tap and saturating packet counter, both driven by put-channel handshakes.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ap_valid_q  <= 1'b0;
            ap_data_q   <= '0;
            ap_last_q   <= 1'b0;
            ap_src_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            ap_valid_q <= out_fire;
            if (out_fire) begin
                ap_data_q <= out_data_q;
                ap_last_q <= out_last_q;
                ap_src_q  <= out_src_q;
                if (out_last_q && (pkt_count_q != {CNT_W{1'b1}})) begin
                    pkt_count_q <= pkt_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign req_ready = req_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign ap_valid  = ap_valid_q;
    assign ap_data   = ap_data_q;
    assign ap_last   = ap_last_q;
    assign ap_src    = ap_src_q;
    assign pkt_count = pkt_count_q;
    assign idle      = (state_q == IDLE) & !out_valid_q;

endmodule

// File: tb/tb_put_channel_arbiter.sv
// Directed bench for put_channel_arbiter (4 requesters, 64-bit data, 4-bit counter build).
module tb_put_channel_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int SRC_W   = 2;
    localparam int CNT_W   = 4;

    logic                      clk;
    logic                      rstn;
    logic                      cfg_enable;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic [SRC_W-1:0]          out_src;
    logic                      ap_valid;
    logic [DATA_W-1:0]         ap_data;
    logic                      ap_last;
    logic [SRC_W-1:0]          ap_src;
    logic [CNT_W-1:0]          pkt_count;
    logic                      idle;

    int checks = 0;
    int errors = 0;

    put_channel_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SRC_W(SRC_W), .CNT_W(CNT_W)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .cfg_enable     (cfg_enable),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_src        (out_src),
        .ap_valid       (ap_valid),
        .ap_data        (ap_data),
        .ap_last        (ap_last),
        .ap_src         (ap_src),
        .pkt_count      (pkt_count),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [63:0] val);
        req_data[idx*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        rstn       = 1'b0;
        cfg_enable = 1'b1;
        out_ready  = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        tick();
        tick();
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        rstn = 1'b1;
        tick();

        // Single 1-beat packet from req2
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        set_data(2, 64'hA5);
        #1;
        check("t2_req_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check("t2_out_valid", 64'(out_valid), 64'd1);
        check("t2_out_data", out_data, 64'hA5);
        check("t2_out_src", 64'(out_src), 64'd2);
        check("t2_ap_valid_early", 64'(ap_valid), 64'd0);
        tick();
        check("t2_ap_valid", 64'(ap_valid), 64'd1);
        check("t2_ap_data", ap_data, 64'hA5);
        check("t2_ap_src", 64'(ap_src), 64'd2);
        check("t2_pkt_count", 64'(pkt_count), 64'd1);
        tick();
        check("t2_ap_pulse_end", 64'(ap_valid), 64'd0);

        // Asynchronous reset with a beat sitting in the output register
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        tick();
        check("t1_pre_out_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("t1_out_valid", 64'(out_valid), 64'd0);
        check("t1_out_data", out_data, 64'd0);
        check("t1_req_ready", 64'(req_ready), 64'd0);
        check("t1_idle", 64'(idle), 64'd1);
        check("t1_pkt_count", 64'(pkt_count), 64'd0);
        check("t1_ap_valid", 64'(ap_valid), 64'd0);
        tick();
        rstn = 1'b1;
        #1;

        // All four valid with 1-beat packets: order 0,1,2,3,0 at one beat per cycle
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 64'h100 + 64'(i));
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t3_req_ready", 64'(req_ready), 64'(1 << (k % 4)));
            tick();
            check("t3_out_src", 64'(out_src), 64'(k % 4));
            check("t3_out_data", out_data, 64'h100 + 64'(k % 4));
            if (k > 0) check("t3_ap_src", 64'(ap_src), 64'((k - 1) % 4));
        end
        req_valid = '0;
        tick();
        check("t3_pkt_count", 64'(pkt_count), 64'd5);

        // req1 3-beat packet while req0 waits (rr_ptr now 1)
        req_valid = 4'b0011;
        req_last  = 4'b0001;
        set_data(0, 64'h00);
        set_data(1, 64'h11);
        #1;
        check("t4_b0_ready", 64'(req_ready), 64'b0010);
        tick();
        check("t4_b0_src", 64'(out_src), 64'd1);
        check("t4_b0_data", out_data, 64'h11);
        set_data(1, 64'h12);
        #1;
        check("t4_b1_ready", 64'(req_ready), 64'b0010);
        tick();
        check("t4_b1_data", out_data, 64'h12);
        set_data(1, 64'h13);
        req_last = 4'b0011;
        #1;
        check("t4_b2_ready", 64'(req_ready), 64'b0010);
        tick();
        check("t4_b2_src", 64'(out_src), 64'd1);
        check("t4_b2_last", 64'(out_last), 64'd1);
        req_valid = 4'b0001;
        #1;
        check("t4_req0_ready", 64'(req_ready), 64'b0001);
        tick();
        check("t4_req0_src", 64'(out_src), 64'd0);
        req_valid = '0;
        tick();
        tick();
        check("t4_pkt_count", 64'(pkt_count), 64'd7);

        // Back-pressure: out_ready low for 5 cycles with a beat held
        out_ready = 1'b0;
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        set_data(2, 64'h55);
        #1;
        check("t5_first_ready", 64'(req_ready), 64'b0100);
        tick();
        set_data(2, 64'h66);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t5_stall_ready", 64'(req_ready), 64'd0);
            check("t5_stall_data", out_data, 64'h55);
            check("t5_stall_valid", 64'(out_valid), 64'd1);
            check("t5_stall_ap", 64'(ap_valid), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("t5_drain_load_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check("t5_refill_valid", 64'(out_valid), 64'd1);
        check("t5_refill_data", out_data, 64'h66);
        check("t5_ap_data", ap_data, 64'h55);
        tick();
        check("t5_out_empty", 64'(out_valid), 64'd0);
        check("t5_ap_data2", ap_data, 64'h66);
        tick();
        check("t5_pkt_count", 64'(pkt_count), 64'd9);

        // cfg_enable drops after beat 1 of a 4-beat packet from req3, req0 pending
        req_valid = 4'b1001;
        req_last  = 4'b0001;
        set_data(3, 64'h30);
        #1;
        check("t6_b0_ready", 64'(req_ready), 64'b1000);
        tick();
        cfg_enable = 1'b0;
        for (int b = 1; b < 4; b++) begin
            set_data(3, 64'h30 + 64'(b));
            if (b == 3) req_last = 4'b1001;
            #1;
            check("t6_lock_ready", 64'(req_ready), 64'b1000);
            tick();
            check("t6_src", 64'(out_src), 64'd3);
            check("t6_data", out_data, 64'h30 + 64'(b));
        end
        req_valid = 4'b0001;
        #1;
        check("t6_no_grant", 64'(req_ready), 64'd0);
        tick();
        check("t6_idle", 64'(idle), 64'd1);
        check("t6_still_no_grant", 64'(req_ready), 64'd0);
        tick();
        check("t6_pkt_count", 64'(pkt_count), 64'd10);
        cfg_enable = 1'b1;
        #1;
        check("t6_regrant", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t6_pkt_count2", 64'(pkt_count), 64'd11);

        // Saturation of the 4-bit counter: six more packets push past 15
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        for (int k = 0; k < 6; k++) tick();
        req_valid = '0;
        tick();
        tick();
        check("t7_pkt_count_sat", 64'(pkt_count), 64'hF);
        check("t7_idle", 64'(idle), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
